// File: rtl/rose_ack_sequencer_if.sv
// Request/ack handshake bundle for rose_ack_sequencer: requester drives a/start,
// sequencer returns the ack pulse plus busy/drop status.
interface rose_ack_sequencer_if #(
  parameter int CNT_W = 4
);
  logic             start;
  logic             a;
  logic             b;
  logic             busy;
  logic             overrun;
  logic [CNT_W-1:0] drop_cnt;

  modport master (output start, a, input b, busy, overrun, drop_cnt);
  modport slave  (input start, a, output b, busy, overrun, drop_cnt);
endinterface

// File: rtl/rose_ack_sequencer.sv
// Answers each rising edge of a with a one-cycle b pulse after FAST_DLY or
// SLOW_DLY cycles; rises arriving while a request is outstanding are dropped.
module rose_ack_sequencer #(
  parameter int FAST_DLY = 1,
  parameter int SLOW_DLY = 2,
  parameter int CNT_W    = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  rose_ack_sequencer_if.slave bus
);
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0]       FAST_V  = 4'(FAST_DLY);
  localparam logic [3:0]       SLOW_V  = 4'(SLOW_DLY);
  localparam logic [CNT_W-1:0] CNT_ONE = 1;

  state_t           state, state_nxt;
  logic [3:0]       cnt, cnt_nxt, dly;
  logic             a_q, rise, b_r, b_nxt, drop, overrun_r;
  logic [CNT_W-1:0] drop_cnt_r;

  assign rise = bus.a & ~a_q;
  assign dly  = bus.start ? FAST_V : SLOW_V;

  // Counter holds the edges left until b is set; b fires when it leaves 1, so
  // $rose(b) lands exactly dly cycles after $rose(a).
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    b_nxt     = 1'b0;
    drop      = 1'b0;
    case (state)
      S_IDLE: begin
        if (rise) begin
          if (dly == 4'd1) begin
            b_nxt = 1'b1;
          end else begin
            cnt_nxt   = dly - 4'd1;
            state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        drop = rise;
        if (cnt == 4'd1) begin
          b_nxt     = 1'b1;
          cnt_nxt   = '0;
          state_nxt = S_IDLE;
        end else begin
          cnt_nxt = cnt - 4'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      cnt        <= '0;
      a_q        <= 1'b0;
      b_r        <= 1'b0;
      overrun_r  <= 1'b0;
      drop_cnt_r <= '0;
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      a_q       <= bus.a;
      b_r       <= b_nxt;
      overrun_r <= drop;
      if (drop && drop_cnt_r != '1) drop_cnt_r <= drop_cnt_r + CNT_ONE;
    end
  end

  assign bus.b        = b_r;
  assign bus.busy     = (state == S_WAIT);
  assign bus.overrun  = overrun_r;
  assign bus.drop_cnt = drop_cnt_r;
endmodule

// File: tb/tb_rose_ack_sequencer.sv
// Scoreboard bench: two sequencer instances (1/2 and 3/5 cycle latencies);
// stimulus queues expected pulse cycles, a negedge monitor pops and compares.
module tb_rose_ack_sequencer;
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  rose_ack_sequencer_if #(.CNT_W(4)) if0 ();
  rose_ack_sequencer_if #(.CNT_W(4)) if1 ();

  rose_ack_sequencer #(.FAST_DLY(1), .SLOW_DLY(2), .CNT_W(4)) dut0 (
    .clk(clk), .rst_n(rst_n), .bus(if0.slave));
  rose_ack_sequencer #(.FAST_DLY(3), .SLOW_DLY(5), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .bus(if1.slave));

  int n_chk = 0, n_fail = 0;
  int qb0[$], qb1[$], qo0[$], qo1[$];
  int dly_f[2] = '{1, 3};
  int dly_s[2] = '{2, 5};
  int bset[2]  = '{-1, -1};
  logic a_prev[2] = '{1'b0, 1'b0};
  int ov1 = 0;
  int ov_base;

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic mon(input string nm, input logic v, input bit has, input int front,
                     output bit pop);
    pop = 1'b0;
    if (has && front < cyc) begin
      n_chk++; n_fail++; pop = 1'b1;
      $display("FAIL %s: pulse expected at cycle %0d is missing", nm, front);
    end else if (v) begin
      n_chk++; pop = has;
      if (!has || front != cyc) begin
        n_fail++;
        $display("FAIL %s: pulse at cycle %0d, expected cycle %0d", nm, cyc, has ? front : -1);
      end
    end
  endtask

  always @(negedge clk) begin
    bit p;
    if (rst_n) begin
      mon("b0", if0.b, qb0.size() > 0, qb0.size() > 0 ? qb0[0] : 0, p);
      if (p) void'(qb0.pop_front());
      mon("b1", if1.b, qb1.size() > 0, qb1.size() > 0 ? qb1[0] : 0, p);
      if (p) void'(qb1.pop_front());
      mon("overrun0", if0.overrun, qo0.size() > 0, qo0.size() > 0 ? qo0[0] : 0, p);
      if (p) void'(qo0.pop_front());
      mon("overrun1", if1.overrun, qo1.size() > 0, qo1.size() > 0 ? qo1[0] : 0, p);
      if (p) void'(qo1.pop_front());
      if (if1.overrun) ov1++;
    end
  end

  // Called just after a posedge; the values are sampled at the next edge (cyc+1).
  task automatic drive(input int d, input logic av, input logic sv);
    int e, dl;
    if (av && !a_prev[d]) begin
      e  = cyc + 1;
      dl = sv ? dly_f[d] : dly_s[d];
      if (e > bset[d]) begin
        bset[d] = e + dl - 1;
        if (d == 0) qb0.push_back(bset[d]); else qb1.push_back(bset[d]);
      end else begin
        if (d == 0) qo0.push_back(e); else qo1.push_back(e);
      end
    end
    a_prev[d] = av;
    if (d == 0) begin if0.a = av; if0.start = sv; end
    else        begin if1.a = av; if1.start = sv; end
  endtask

  task automatic step(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0;
    if0.a = 1'b0; if0.start = 1'b0;
    if1.a = 1'b0; if1.start = 1'b0;
    step(2);
    chk("rst b0", if0.b, 0);          chk("rst busy0", if0.busy, 0);
    chk("rst overrun0", if0.overrun, 0); chk("rst drop_cnt0", if0.drop_cnt, 0);
    chk("rst b1", if1.b, 0);          chk("rst busy1", if1.busy, 0);
    rst_n = 1'b1;
    step(2);

    // fast mode, latency 1: busy never asserts
    drive(0, 1'b1, 1'b1); step;
    chk("fast busy0 at k", if0.busy, 0);
    step;
    chk("fast busy0 at k+1", if0.busy, 0);
    drive(0, 1'b0, 1'b1); step(3);
    chk("fast drop_cnt0", if0.drop_cnt, 0);

    // slow mode; start toggling after detection must not matter
    drive(0, 1'b1, 1'b0); step;
    chk("slow busy0 at k", if0.busy, 1);
    drive(0, 1'b1, 1'b1); step;
    chk("slow busy0 at k+1", if0.busy, 0);
    step;
    drive(0, 1'b0, 1'b0); step(3);

    // rise on the b-falling edge is accepted
    drive(0, 1'b1, 1'b0); step;
    drive(0, 1'b0, 1'b0); step;
    drive(0, 1'b1, 1'b0); step;
    drive(0, 1'b0, 1'b0); step(4);
    chk("refire drop_cnt0", if0.drop_cnt, 0);

    // 3/5 instance, alternating mode, rises 8 apart
    for (int i = 0; i < 4; i++) begin
      drive(1, 1'b1, (i % 2) == 0); step;
      drive(1, 1'b0, 1'b0); step(7);
    end
    chk("alt drop_cnt1", if1.drop_cnt, 0);

    // rise on the b-setting edge is dropped
    drive(1, 1'b1, 1'b1); step;
    drive(1, 1'b0, 1'b1); step;
    drive(1, 1'b1, 1'b1); step;
    chk("bset busy1", if1.busy, 0);
    drive(1, 1'b0, 1'b1); step(4);
    chk("bset drop_cnt1", if1.drop_cnt, 1);

    // rise on the b-falling edge is accepted (fast = 3)
    drive(1, 1'b1, 1'b1); step(2);
    drive(1, 1'b0, 1'b1); step;
    drive(1, 1'b1, 1'b1); step;
    drive(1, 1'b0, 1'b0); step(4);
    chk("bfall drop_cnt1", if1.drop_cnt, 1);

    // toggle a every cycle in slow mode: 10 accepts, 20 drops
    ov_base = ov1;
    for (int i = 0; i < 60; i++) begin
      drive(1, (i % 2) == 0, 1'b0); step;
    end
    drive(1, 1'b0, 1'b0); step(8);
    chk("sat drop_cnt1", if1.drop_cnt, 15);
    chk("sat overrun pulses", ov1 - ov_base, 20);

    // reset one cycle after a slow rise cancels the pending ack
    drive(0, 1'b1, 1'b0); step;
    rst_n = 1'b0;
    qb0.delete();
    a_prev[0] = 1'b0; a_prev[1] = 1'b0;
    bset[0] = -1; bset[1] = -1;
    #1;
    chk("async rst busy0", if0.busy, 0);
    chk("async rst drop_cnt1", if1.drop_cnt, 0);
    step(2);
    rst_n = 1'b1;
    drive(0, 1'b1, 1'b0); step;
    chk("post-rst busy0", if0.busy, 1);
    drive(0, 1'b0, 1'b0); step(4);

    chk("qb0 drained", qb0.size(), 0);
    chk("qb1 drained", qb1.size(), 0);
    chk("qo0 drained", qo0.size(), 0);
    chk("qo1 drained", qo1.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
